// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, registers the fetched instruction into IF/ID,
// and applies reset > redirect > stall > advance priority on every rising edge.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic [31:0] instruction,
    output logic [31:0] pc_out,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic [31:0] fetch_count
);

    logic [31:0] pc_q,          pc_d;
    logic [31:0] ifIdPc_q,      ifIdPc_d;
    logic [31:0] ifIdPcPlus4_q, ifIdPcPlus4_d;
    logic [31:0] ifIdInstr_q,   ifIdInstr_d;
    logic        ifIdValid_q,   ifIdValid_d;
    logic [31:0] fetchCount_q,  fetchCount_d;

    logic [31:0] pcPlus4;
    logic [31:0] redirectTarget;

    assign pcPlus4        = pc_q + 32'd4;
    assign redirectTarget = {redirect_pc[31:2], 2'b00};

    // Reset is handled in the register process; here redirect flushes even when stalled.
    always_comb begin
        pc_d          = pc_q;
        ifIdPc_d      = ifIdPc_q;
        ifIdPcPlus4_d = ifIdPcPlus4_q;
        ifIdInstr_d   = ifIdInstr_q;
        ifIdValid_d   = ifIdValid_q;
        fetchCount_d  = fetchCount_q;

        if (redirect) begin
            pc_d          = redirectTarget;
            ifIdPc_d      = 32'd0;
            ifIdPcPlus4_d = 32'd0;
            ifIdInstr_d   = NOP_INSTR;
            ifIdValid_d   = 1'b0;
        end else if (!stall) begin
            pc_d          = pcPlus4;
            ifIdPc_d      = pc_q;
            ifIdPcPlus4_d = pcPlus4;
            ifIdInstr_d   = instruction;
            ifIdValid_d   = 1'b1;
            fetchCount_d  = fetchCount_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            ifIdPc_q      <= 32'd0;
            ifIdPcPlus4_q <= 32'd0;
            ifIdInstr_q   <= NOP_INSTR;
            ifIdValid_q   <= 1'b0;
            fetchCount_q  <= 32'd0;
        end else begin
            pc_q          <= pc_d;
            ifIdPc_q      <= ifIdPc_d;
            ifIdPcPlus4_q <= ifIdPcPlus4_d;
            ifIdInstr_q   <= ifIdInstr_d;
            ifIdValid_q   <= ifIdValid_d;
            fetchCount_q  <= fetchCount_d;
        end
    end

    assign pc_out         = pc_q;
    assign if_id_pc       = ifIdPc_q;
    assign if_id_pc_plus4 = ifIdPcPlus4_q;
    assign if_id_instr    = ifIdInstr_q;
    assign if_id_valid    = ifIdValid_q;
    assign fetch_count    = fetchCount_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then random traffic, all compared
// against a cycle-level model of the fetch rules with a 32-word instruction memory.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirectPc;
    logic [31:0] instruction;
    logic [31:0] pcOut;
    logic [31:0] ifIdPc;
    logic [31:0] ifIdPcPlus4;
    logic [31:0] ifIdInstr;
    logic        ifIdValid;
    logic [31:0] fetchCount;

    logic [31:0] mem [32];

    int checks = 0;
    int errors = 0;

    // Model state
    logic [31:0] mPc;
    logic [31:0] mIfPc;
    logic [31:0] mIfPc4;
    logic [31:0] mInstr;
    logic        mValid;
    logic [31:0] mCount;

    fetch_stage #(
        .RESET_PC (RESET_PC),
        .NOP_INSTR(NOP_INSTR)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_pc   (redirectPc),
        .instruction   (instruction),
        .pc_out        (pcOut),
        .if_id_pc      (ifIdPc),
        .if_id_pc_plus4(ifIdPcPlus4),
        .if_id_instr   (ifIdInstr),
        .if_id_valid   (ifIdValid),
        .fetch_count   (fetchCount)
    );

    always #5 clk = ~clk;

    // Instruction memory: combinational, indexed by PC[6:2], drives 0 during reset.
    assign instruction = rst ? 32'd0 : mem[pcOut[6:2]];

    task automatic checkOne(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkOne({tag, ".pc"},     pcOut,                mPc);
        checkOne({tag, ".ifpc"},   ifIdPc,               mIfPc);
        checkOne({tag, ".ifpc4"},  ifIdPcPlus4,          mIfPc4);
        checkOne({tag, ".instr"},  ifIdInstr,            mInstr);
        checkOne({tag, ".valid"},  {31'd0, ifIdValid},   {31'd0, mValid});
        checkOne({tag, ".count"},  fetchCount,           mCount);
    endtask

    // Drive one cycle of inputs, advance the model by the same edge, sample 1ns later.
    task automatic applyStimulus(input logic r, input logic s, input logic rd, input logic [31:0] rpc);
        logic [31:0] fetched;
        rst        = r;
        stall      = s;
        redirect   = rd;
        redirectPc = rpc;
        fetched    = mem[mPc[6:2]];
        @(posedge clk);
        if (r) begin
            mPc    = RESET_PC;
            mIfPc  = 32'd0;
            mIfPc4 = 32'd0;
            mInstr = NOP_INSTR;
            mValid = 1'b0;
            mCount = 32'd0;
        end else if (rd) begin
            mPc    = rpc & 32'hFFFF_FFFC;
            mIfPc  = 32'd0;
            mIfPc4 = 32'd0;
            mInstr = NOP_INSTR;
            mValid = 1'b0;
        end else if (!s) begin
            mIfPc  = mPc;
            mIfPc4 = mPc + 32'd4;
            mInstr = fetched;
            mValid = 1'b1;
            mCount = mCount + 32'd1;
            mPc    = mPc + 32'd4;
        end
        #1;
    endtask

    initial begin
        mem[0] = 32'h0050_0093;
        mem[1] = 32'h00A0_0113;
        for (int i = 2; i < 32; i++) mem[i] = $urandom;
        mPc = 'x; mIfPc = 'x; mIfPc4 = 'x; mInstr = 'x; mValid = 1'bx; mCount = 'x;

        // Reset held for two cycles
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
        checkOutput("reset");

        // Straight-line fetch after reset release
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        checkOutput("fetch1");
        checkOne("fetch1.lit.instr", ifIdInstr, 32'h0050_0093);
        checkOne("fetch1.lit.ifpc", ifIdPc, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        checkOutput("fetch2");
        checkOne("fetch2.lit.ifpc4", ifIdPcPlus4, 32'd8);
        checkOne("fetch2.lit.count", fetchCount, 32'd2);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        checkOne("prestall.lit.pc", pcOut, 32'h10);

        // Stall for three cycles, then release
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
            checkOutput("stall");
            checkOne("stall.lit.pc", pcOut, 32'h10);
            checkOne("stall.lit.count", fetchCount, 32'd4);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        checkOutput("unstall");
        checkOne("unstall.lit.ifpc", ifIdPc, 32'h10);

        // Redirect from PC 0x0C to 0x40
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0C);
        checkOne("pre_redirect.lit.pc", pcOut, 32'h0C);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h40);
        checkOutput("redirect");
        checkOne("redirect.lit.pc", pcOut, 32'h40);
        checkOne("redirect.lit.instr", ifIdInstr, NOP_INSTR);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        checkOutput("post_redirect");
        checkOne("post_redirect.lit.ifpc", ifIdPc, 32'h40);
        checkOne("post_redirect.lit.valid", {31'd0, ifIdValid}, 32'd1);

        // Redirect beats stall; misaligned target is aligned
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h23);
        checkOutput("redir_stall");
        checkOne("redir_stall.lit.pc", pcOut, 32'h20);
        checkOne("redir_stall.lit.valid", {31'd0, ifIdValid}, 32'd0);

        // Reset wins over stall and redirect
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h80);
        checkOutput("reset_all");
        checkOne("reset_all.lit.count", fetchCount, 32'd0);

        // PC wrap-around
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE);
        checkOne("wrap.lit.pre_pc", pcOut, 32'hFFFF_FFFC);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        checkOutput("wrap");
        checkOne("wrap.lit.pc", pcOut, 32'd0);
        checkOne("wrap.lit.ifpc4", ifIdPcPlus4, 32'd0);
        checkOne("wrap.lit.ifpc", ifIdPc, 32'hFFFF_FFFC);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 49) == 0),
                          ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 7) == 0),
                          $urandom);
            checkOutput("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
